// File: rtl/dcp_run_ctrl_if.sv
// Command/status bundle between the DCP command modules (master) and the
// CPU run controller (slave).
interface dcp_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_step;
    logic             cmd_run;
    logic             cmd_halt;
    logic [CNT_W-1:0] run_limit;
    logic             bp_we;
    logic [1:0]       bp_idx;
    logic [31:0]      bp_addr;
    logic             bp_en;
    logic [31:0]      pc_chk;

    logic             clk_cpu;
    logic             busy;
    logic             done;
    logic [1:0]       stop_reason;
    logic [1:0]       hit_idx;
    logic [CNT_W-1:0] cycle_cnt;

    // Commands are single-cycle pulses; there is no back-pressure. A command
    // is consumed only while the controller is idle (busy=0, done=0), and
    // done pulses for exactly one cycle, with busy already low, when it ends.
    modport master (
        output cmd_step, cmd_run, cmd_halt, run_limit,
        output bp_we, bp_idx, bp_addr, bp_en, pc_chk,
        input  clk_cpu, busy, done, stop_reason, hit_idx, cycle_cnt
    );

    modport slave (
        input  cmd_step, cmd_run, cmd_halt, run_limit,
        input  bp_we, bp_idx, bp_addr, bp_en, pc_chk,
        output clk_cpu, busy, done, stop_reason, hit_idx, cycle_cnt
    );
endinterface

// File: rtl/dcp_run_ctrl.sv
// CPU clock generator for the serial debug unit: single-step and
// run-until-stop share one pulse engine; breakpoints are checked after each pulse.
module dcp_run_ctrl #(
    parameter int NUM_BP   = 2,
    parameter int PULSE_HI = 2,
    parameter int PULSE_LO = 2,
    parameter int CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rstn,
    dcp_run_ctrl_if.slave  ctl,
    output logic [2:0]     dbg_state
);
    localparam int PH_MAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             step_q, step_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       reason_q, reason_d;
    logic [1:0]       hit_q, hit_d;
    logic             clk_cpu_q, clk_cpu_d;
    logic [31:0]      bp_addr_q [NUM_BP];
    logic [31:0]      bp_addr_d [NUM_BP];
    logic             bp_en_q   [NUM_BP];
    logic             bp_en_d   [NUM_BP];
    logic             bp_hit;
    logic [1:0]       bp_hit_idx;
    logic             busy_o, done_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            step_q    <= 1'b0;
            halt_q    <= 1'b0;
            cnt_q     <= '0;
            reason_q  <= 2'd0;
            hit_q     <= 2'd0;
            clk_cpu_q <= 1'b0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
                bp_en_q[i]   <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            step_q    <= step_d;
            halt_q    <= halt_d;
            cnt_q     <= cnt_d;
            reason_q  <= reason_d;
            hit_q     <= hit_d;
            clk_cpu_q <= clk_cpu_d;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= bp_addr_d[i];
                bp_en_q[i]   <= bp_en_d[i];
            end
        end
    end

    // Indices at or above NUM_BP never match, so such writes fall away.
    always_comb begin
        for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_d[i] = bp_addr_q[i];
            bp_en_d[i]   = bp_en_q[i];
            if (ctl.bp_we && ctl.bp_idx == 2'(i)) begin
                bp_addr_d[i] = ctl.bp_addr;
                bp_en_d[i]   = ctl.bp_en;
            end
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        bp_hit     = 1'b0;
        bp_hit_idx = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && bp_addr_q[i] == ctl.pc_chk) begin
                bp_hit     = 1'b1;
                bp_hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        step_d   = step_q;
        halt_d   = halt_q;
        cnt_d    = cnt_q;
        reason_d = reason_q;
        hit_d    = hit_q;
        if (busy_o && ctl.cmd_halt) halt_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ctl.cmd_step || ctl.cmd_run) begin
                    state_d = S_HIGH;
                    ph_d    = '0;
                    step_d  = ctl.cmd_step;
                    halt_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_HIGH: begin
                if (ph_q == PH_W'(PULSE_HI - 1)) begin
                    state_d = S_LOW;
                    ph_d    = '0;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_LOW: begin
                if (ph_q == PH_W'(PULSE_LO - 1)) begin
                    state_d = S_CHECK;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (step_q) begin
                    reason_d = 2'd0;
                end else if (halt_q) begin
                    reason_d = 2'd2;
                end else if (bp_hit) begin
                    reason_d = 2'd1;
                    hit_d    = bp_hit_idx;
                end else if (ctl.run_limit != '0 && cnt_q == ctl.run_limit) begin
                    reason_d = 2'd3;
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        clk_cpu_d = (state_d == S_HIGH);
        case (state_q)
            S_HIGH, S_LOW, S_CHECK: busy_o = 1'b1;
            S_DONE:                 done_o = 1'b1;
            default:                busy_o = 1'b0;
        endcase
    end

    assign ctl.clk_cpu     = clk_cpu_q;
    assign ctl.busy        = busy_o;
    assign ctl.done        = done_o;
    assign ctl.stop_reason = reason_q;
    assign ctl.hit_idx     = hit_q;
    assign ctl.cycle_cnt   = cnt_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_dcp_run_ctrl.sv
// Bench for dcp_run_ctrl: vector table, hand-written corner sequences and
// randomized runs scored against a pulse-by-pulse model of the stop rules.
module tb_dcp_run_ctrl;
  localparam int CNT_W  = 32;
  localparam int HI     = 2;
  localparam int LO     = 2;
  localparam int NUM_BP = 2;

  typedef struct {
    logic        step;
    logic [31:0] limit;
    logic [31:0] pc0;
    logic [31:0] a0;
    logic        e0;
    logic [31:0] a1;
    logic        e1;
    int          halt_at;
    int          rerun_at;
    logic [1:0]  reason;
    logic [1:0]  hit;
    logic [31:0] cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  dcp_run_ctrl_if #(.CNT_W(CNT_W)) ifc();

  dcp_run_ctrl #(
    .NUM_BP(NUM_BP), .PULSE_HI(HI), .PULSE_LO(LO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .ctl(ifc.slave), .dbg_state(dbg_state)
  );

  // CPU stand-in: PC advances by 4 on every clk_cpu rise.
  int unsigned rise_total = 0;
  int unsigned rise_base  = 0;
  logic [31:0] pc_base    = 32'd0;
  always @(posedge ifc.clk_cpu) rise_total <= rise_total + 1;
  assign ifc.pc_chk = pc_base + ((rise_total - rise_base) << 2);

  function automatic int unsigned pulses();
    return rise_total - rise_base;
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  logic [31:0] m_addr [2];
  logic        m_en   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk pulse by pulse; after pulse n the PC is pc0+4n.
  function automatic logic [35:0] model(input logic step, input logic [31:0] pc0,
                                        input logic [31:0] limit, input int halt_at);
    logic [31:0] pc;
    if (step) return {2'd0, 2'd0, 32'd1};
    for (int n = 1; n <= 64; n++) begin
      pc = pc0 + 32'(4 * n);
      if (n == halt_at) return {2'd2, 2'd0, 32'(n)};
      for (int i = 0; i < 2; i++)
        if (m_en[i] && m_addr[i] == pc) return {2'd1, 2'(i), 32'(n)};
      if (limit != 0 && limit == 32'(n)) return {2'd3, 2'd0, 32'(n)};
    end
    return '1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bp_write(input logic [1:0] idx, input logic [31:0] addr, input logic en);
    ifc.bp_we = 1'b1; ifc.bp_idx = idx; ifc.bp_addr = addr; ifc.bp_en = en;
    @(negedge clk);
    ifc.bp_we = 1'b0;
  endtask

  task automatic start_cmd(input logic step, input logic run, input logic [31:0] pc0);
    pc_base   = pc0;
    rise_base = rise_total;
    ifc.cmd_step = step; ifc.cmd_run = run;
    @(negedge clk);
    ifc.cmd_step = 1'b0; ifc.cmd_run = 1'b0;
  endtask

  task automatic wait_done(input int halt_at, input int rerun_at,
                           output logic ok, output int hi_samples);
    logic halt_sent, rerun_sent;
    halt_sent = 1'b0; rerun_sent = 1'b0; ok = 1'b0; hi_samples = 0;
    for (int c = 0; c < 2000; c++) begin
      ifc.cmd_halt = 1'b0; ifc.cmd_run = 1'b0;
      if (ifc.done) begin ok = 1'b1; break; end
      if (ifc.clk_cpu) hi_samples++;
      if (!halt_sent && halt_at > 0 && pulses() == halt_at && ifc.clk_cpu) begin
        ifc.cmd_halt = 1'b1; halt_sent = 1'b1;
      end
      if (!rerun_sent && rerun_at > 0 && pulses() == rerun_at && ifc.clk_cpu) begin
        ifc.cmd_run = 1'b1; rerun_sent = 1'b1;
      end
      @(negedge clk);
    end
    ifc.cmd_halt = 1'b0; ifc.cmd_run = 1'b0;
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    logic ok;
    int   hi;
    bp_write(2'd0, v.a0, v.e0);
    bp_write(2'd1, v.a1, v.e1);
    ifc.run_limit = v.limit;
    start_cmd(v.step, !v.step, v.pc0);
    wait_done(v.halt_at, v.rerun_at, ok, hi);
    if (ok) begin
      chk({tag, ".reason"}, 32'(ifc.stop_reason), 32'(v.reason));
      chk({tag, ".cycle_cnt"}, ifc.cycle_cnt, v.cnt);
      chk({tag, ".rises"}, 32'(pulses()), v.cnt);
      chk({tag, ".hi_width"}, 32'(hi), v.cnt * 32'(HI));
      chk({tag, ".busy_at_done"}, 32'(ifc.busy), 32'd0);
      if (v.reason == 2'd1) chk({tag, ".hit_idx"}, 32'(ifc.hit_idx), 32'(v.hit));
    end
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  vec_t vt[11];

  initial begin
    logic       ok;
    int         hi;
    logic [5:0] clk_pat, done_pat;
    logic [35:0] exp_rec;
    vec_t       v;

    //          step  limit  pc0    a0     e0 a1     e1 halt rerun rsn hit cnt
    vt[0]  = '{1'b1, 32'd0, 32'h00, 32'h04, 1, 32'h00, 0, 0, 0, 2'd0, 2'd0, 32'd1};
    vt[1]  = '{1'b0, 32'd0, 32'h00, 32'h10, 1, 32'h00, 0, 0, 0, 2'd1, 2'd0, 32'd4};
    vt[2]  = '{1'b0, 32'd0, 32'h00, 32'h20, 1, 32'h20, 1, 0, 0, 2'd1, 2'd0, 32'd8};
    vt[3]  = '{1'b0, 32'd0, 32'h20, 32'h20, 1, 32'h24, 1, 0, 0, 2'd1, 2'd1, 32'd1};
    vt[4]  = '{1'b0, 32'd0, 32'h00, 32'h00, 0, 32'h00, 0, 3, 0, 2'd2, 2'd0, 32'd3};
    vt[5]  = '{1'b0, 32'd5, 32'h00, 32'h00, 0, 32'h00, 0, 0, 0, 2'd3, 2'd0, 32'd5};
    vt[6]  = '{1'b0, 32'd0, 32'h00, 32'h08, 1, 32'h00, 0, 2, 0, 2'd2, 2'd0, 32'd2};
    vt[7]  = '{1'b0, 32'd0, 32'h00, 32'h18, 1, 32'h00, 0, 0, 2, 2'd1, 2'd0, 32'd6};
    vt[8]  = '{1'b0, 32'd2, 32'h00, 32'h08, 1, 32'h00, 0, 0, 0, 2'd1, 2'd0, 32'd2};
    vt[9]  = '{1'b0, 32'd3, 32'h00, 32'h08, 0, 32'h10, 1, 0, 0, 2'd3, 2'd0, 32'd3};
    vt[10] = '{1'b0, 32'd0, 32'h00, 32'h08, 0, 32'h0C, 1, 0, 0, 2'd1, 2'd1, 32'd3};

    ifc.cmd_step = 0; ifc.cmd_run = 0; ifc.cmd_halt = 0; ifc.run_limit = '0;
    ifc.bp_we = 0; ifc.bp_idx = 0; ifc.bp_addr = 0; ifc.bp_en = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.clk_cpu", 32'(ifc.clk_cpu), 32'd0);
    chk("rst.busy", 32'(ifc.busy), 32'd0);
    chk("rst.done", 32'(ifc.done), 32'd0);
    chk("rst.stop_reason", 32'(ifc.stop_reason), 32'd0);
    chk("rst.hit_idx", 32'(ifc.hit_idx), 32'd0);
    chk("rst.cycle_cnt", ifc.cycle_cnt, 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Step latency: high k+1..k+2, low after, done at k+6
    start_cmd(1'b1, 1'b0, 32'd0);
    chk("step.busy", 32'(ifc.busy), 32'd1);
    for (int j = 5; j >= 0; j--) begin
      clk_pat[j]  = ifc.clk_cpu;
      done_pat[j] = ifc.done;
      if (j > 0) @(negedge clk);
    end
    chk("step.clk_pattern", 32'(clk_pat), 32'b110000);
    chk("step.done_pattern", 32'(done_pat), 32'b000001);
    chk("step.reason", 32'(ifc.stop_reason), 32'd0);
    chk("step.cycle_cnt", ifc.cycle_cnt, 32'd1);
    @(negedge clk);

    foreach (vt[i]) run_case(vt[i], $sformatf("vec%0d", i));

    // Step and run together: step wins even with a breakpoint one pulse away
    bp_write(2'd0, 32'h4, 1'b1);
    ifc.run_limit = '0;
    start_cmd(1'b1, 1'b1, 32'd0);
    wait_done(0, 0, ok, hi);
    chk("both.reason", 32'(ifc.stop_reason), 32'd0);
    chk("both.cycle_cnt", ifc.cycle_cnt, 32'd1);
    @(negedge clk);

    // Halt while idle leaves nothing behind
    bp_write(2'd0, 32'h0, 1'b0);
    ifc.cmd_halt = 1'b1; @(negedge clk); ifc.cmd_halt = 1'b0;
    chk("idle_halt.busy", 32'(ifc.busy), 32'd0);
    ifc.run_limit = 32'd2;
    start_cmd(1'b0, 1'b1, 32'd0);
    wait_done(0, 0, ok, hi);
    chk("idle_halt.reason", 32'(ifc.stop_reason), 32'd3);
    chk("idle_halt.cycle_cnt", ifc.cycle_cnt, 32'd2);
    @(negedge clk);

    // Reset during HIGH of a run
    bp_write(2'd0, 32'h10, 1'b1);
    ifc.run_limit = '0;
    start_cmd(1'b0, 1'b1, 32'd0);
    chk("mid_rst.pre_clk_cpu", 32'(ifc.clk_cpu), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst.clk_cpu", 32'(ifc.clk_cpu), 32'd0);
    chk("mid_rst.busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    ifc.run_limit = 32'd6;
    start_cmd(1'b0, 1'b1, 32'd0);
    wait_done(0, 0, ok, hi);
    chk("post_rst.bp_cleared_reason", 32'(ifc.stop_reason), 32'd3);
    chk("post_rst.cycle_cnt", ifc.cycle_cnt, 32'd6);
    @(negedge clk);
    start_cmd(1'b1, 1'b0, 32'd0);
    wait_done(0, 0, ok, hi);
    chk("post_rst.step_reason", 32'(ifc.stop_reason), 32'd0);
    chk("post_rst.step_cnt", ifc.cycle_cnt, 32'd1);
    @(negedge clk);

    // Randomized runs against the model
    for (int it = 0; it < 30; it++) begin
      v.pc0 = 32'($urandom_range(0, 255)) << 2;
      for (int i = 0; i < 2; i++) begin
        m_en[i]   = 1'($urandom_range(0, 1));
        m_addr[i] = v.pc0 + 32'(4 * $urandom_range(0, 10));
        bp_write(2'(i), m_addr[i], m_en[i]);
      end
      if ($urandom_range(0, 1) == 1) bp_write(2'($urandom_range(2, 3)), v.pc0 + 32'd4, 1'b1);
      v.step     = ($urandom_range(0, 5) == 0);
      v.limit    = 32'($urandom_range(0, 10));
      v.halt_at  = int'($urandom_range(1, 12));
      v.rerun_at = int'($urandom_range(0, 3));
      exp_q.push_back(model(v.step, v.pc0, v.limit, v.halt_at));
      ifc.run_limit = v.limit;
      start_cmd(v.step, !v.step, v.pc0);
      wait_done(v.halt_at, v.rerun_at, ok, hi);
      exp_rec = exp_q.pop_front();
      if (ok) begin
        chk($sformatf("rnd%0d.reason", it), 32'(ifc.stop_reason), 32'(exp_rec[35:34]));
        chk($sformatf("rnd%0d.cycle_cnt", it), ifc.cycle_cnt, exp_rec[31:0]);
        chk($sformatf("rnd%0d.rises", it), 32'(pulses()), exp_rec[31:0]);
        if (exp_rec[35:34] == 2'd1)
          chk($sformatf("rnd%0d.hit_idx", it), 32'(ifc.hit_idx), 32'(exp_rec[33:32]));
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
